// File: rtl/scalu_issue_arb_pkg.sv
// Shared scalar-ALU issue constants and types, common to exers, the issue arbiter and scalu.
package scalu_issue_arb_pkg;

  localparam int ROBID_W = 7;
  localparam int XLEN    = 32;
  localparam int OP_W    = 5;
  localparam int PREG_W  = 6;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Distance from the ROB head; the subtract wraps, so a smaller value is older.
  function automatic logic [ROBID_W-1:0] rob_age(input logic [ROBID_W-1:0] robid,
                                                 input logic [ROBID_W-1:0] head);
    return robid - head;
  endfunction

endpackage

// File: rtl/scalu_issue_slot.sv
// One-entry holding slot for an issue port: FULL flag plus micro-op fields.
module scalu_issue_slot
  import scalu_issue_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_drain,
  input  logic               i_flush,
  input  logic [OP_W-1:0]    i_op,
  input  logic [ROBID_W-1:0] i_robid,
  input  logic [PREG_W-1:0]  i_rd,
  input  logic [XLEN-1:0]    i_op1,
  input  logic [XLEN-1:0]    i_op2,
  output logic               o_full,
  output logic [OP_W-1:0]    o_op,
  output logic [ROBID_W-1:0] o_robid,
  output logic [PREG_W-1:0]  o_rd,
  output logic [XLEN-1:0]    o_op1,
  output logic [XLEN-1:0]    o_op2
);

  slot_state_t r_state;
  slot_state_t w_state_nxt;

  logic [OP_W-1:0]    r_op;
  logic [ROBID_W-1:0] r_robid;
  logic [PREG_W-1:0]  r_rd;
  logic [XLEN-1:0]    r_op1;
  logic [XLEN-1:0]    r_op2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SLOT_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // A load wins over a drain so a slot emptying this cycle can refill at once.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush)      w_state_nxt = SLOT_EMPTY;
    else if (i_load)  w_state_nxt = SLOT_FULL;
    else if (i_drain) w_state_nxt = SLOT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (i_load && !i_flush) begin
      r_op    <= i_op;
      r_robid <= i_robid;
      r_rd    <= i_rd;
      r_op1   <= i_op1;
      r_op2   <= i_op2;
    end
  end

  assign o_full  = (r_state == SLOT_FULL);
  assign o_op    = r_op;
  assign o_robid = r_robid;
  assign o_rd    = r_rd;
  assign o_op1   = r_op1;
  assign o_op2   = r_op2;

endmodule

// File: rtl/scalu_issue_arb.sv
// Arbitrates the scalar ALU between two issue ports, oldest ROB entry first.
module scalu_issue_arb
  import scalu_issue_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               exers0_issue,
  input  logic [OP_W-1:0]    exers0_op,
  input  logic [ROBID_W-1:0] exers0_robid,
  input  logic [PREG_W-1:0]  exers0_rd,
  input  logic [XLEN-1:0]    exers0_op1,
  input  logic [XLEN-1:0]    exers0_op2,
  input  logic               exers1_issue,
  input  logic [OP_W-1:0]    exers1_op,
  input  logic [ROBID_W-1:0] exers1_robid,
  input  logic [PREG_W-1:0]  exers1_rd,
  input  logic [XLEN-1:0]    exers1_op1,
  input  logic [XLEN-1:0]    exers1_op2,
  output logic               arb_exers0_stall,
  output logic               arb_exers1_stall,
  output logic               arb_scalu_issue,
  output logic [OP_W-1:0]    arb_scalu_op,
  output logic [ROBID_W-1:0] arb_scalu_robid,
  output logic [PREG_W-1:0]  arb_scalu_rd,
  output logic [XLEN-1:0]    arb_scalu_op1,
  output logic [XLEN-1:0]    arb_scalu_op2,
  input  logic               scalu_stall,
  input  logic [ROBID_W-1:0] rob_head,
  input  logic               rob_flush
);

  logic               w_full0, w_full1;
  logic [OP_W-1:0]    w_s0_op, w_s1_op;
  logic [ROBID_W-1:0] w_s0_robid, w_s1_robid;
  logic [PREG_W-1:0]  w_s0_rd, w_s1_rd;
  logic [XLEN-1:0]    w_s0_op1, w_s1_op1;
  logic [XLEN-1:0]    w_s0_op2, w_s1_op2;

  logic [ROBID_W-1:0] w_age0, w_age1;
  logic               w_grant0, w_grant1;
  logic               w_load0, w_load1;

  assign w_age0 = rob_age(w_s0_robid, rob_head);
  assign w_age1 = rob_age(w_s1_robid, rob_head);

  // Equal ages cannot occur legally; slot 0 takes the tie.
  assign w_grant0 = !scalu_stall && w_full0 && (!w_full1 || (w_age0 <= w_age1));
  assign w_grant1 = !scalu_stall && w_full1 && (!w_full0 || (w_age1 <  w_age0));

  // Handshake: exersN_issue is valid, ~arb_exersN_stall is ready; a transfer
  // happens on an edge where both are true, and the requester holds its
  // micro-op unchanged until then. Toward scalu, arb_scalu_issue is valid and
  // ~scalu_stall is ready.
  assign arb_exers0_stall = w_full0 && !w_grant0;
  assign arb_exers1_stall = w_full1 && !w_grant1;
  assign w_load0 = exers0_issue && !arb_exers0_stall;
  assign w_load1 = exers1_issue && !arb_exers1_stall;

  scalu_issue_slot u_slot0 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load0),
    .i_drain (w_grant0),
    .i_flush (rob_flush),
    .i_op    (exers0_op),
    .i_robid (exers0_robid),
    .i_rd    (exers0_rd),
    .i_op1   (exers0_op1),
    .i_op2   (exers0_op2),
    .o_full  (w_full0),
    .o_op    (w_s0_op),
    .o_robid (w_s0_robid),
    .o_rd    (w_s0_rd),
    .o_op1   (w_s0_op1),
    .o_op2   (w_s0_op2)
  );

  scalu_issue_slot u_slot1 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load1),
    .i_drain (w_grant1),
    .i_flush (rob_flush),
    .i_op    (exers1_op),
    .i_robid (exers1_robid),
    .i_rd    (exers1_rd),
    .i_op1   (exers1_op1),
    .i_op2   (exers1_op2),
    .o_full  (w_full1),
    .o_op    (w_s1_op),
    .o_robid (w_s1_robid),
    .o_rd    (w_s1_rd),
    .o_op1   (w_s1_op1),
    .o_op2   (w_s1_op2)
  );

  assign arb_scalu_issue = w_grant0 || w_grant1;
  assign arb_scalu_op    = w_grant1 ? w_s1_op    : w_s0_op;
  assign arb_scalu_robid = w_grant1 ? w_s1_robid : w_s0_robid;
  assign arb_scalu_rd    = w_grant1 ? w_s1_rd    : w_s0_rd;
  assign arb_scalu_op1   = w_grant1 ? w_s1_op1   : w_s0_op1;
  assign arb_scalu_op2   = w_grant1 ? w_s1_op2   : w_s0_op2;

endmodule

// File: tb/tb_scalu_issue_arb.sv
// Directed vector bench for scalu_issue_arb: per-cycle table plus reset/flush/stall sequences.
module tb_scalu_issue_arb;
  import scalu_issue_arb_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               exers0_issue, exers1_issue;
  logic [OP_W-1:0]    exers0_op, exers1_op;
  logic [ROBID_W-1:0] exers0_robid, exers1_robid;
  logic [PREG_W-1:0]  exers0_rd, exers1_rd;
  logic [XLEN-1:0]    exers0_op1, exers1_op1, exers0_op2, exers1_op2;
  logic               arb_exers0_stall, arb_exers1_stall, arb_scalu_issue;
  logic [OP_W-1:0]    arb_scalu_op;
  logic [ROBID_W-1:0] arb_scalu_robid;
  logic [PREG_W-1:0]  arb_scalu_rd;
  logic [XLEN-1:0]    arb_scalu_op1, arb_scalu_op2;
  logic               scalu_stall;
  logic [ROBID_W-1:0] rob_head;
  logic               rob_flush;

  int total = 0;
  int bad   = 0;

  logic [ROBID_W-1:0] exp_q[$];

  typedef struct {
    logic               iss0;
    logic [ROBID_W-1:0] r0;
    logic               iss1;
    logic [ROBID_W-1:0] r1;
    logic [ROBID_W-1:0] head;
    logic               ss;
    logic               fl;
    logic               e_iss;
    logic [ROBID_W-1:0] e_rid;
    logic               e_st0;
    logic               e_st1;
  } vec_t;

  vec_t vq[$];

  scalu_issue_arb dut (
    .clk              (clk),
    .rst              (rst),
    .exers0_issue     (exers0_issue),
    .exers0_op        (exers0_op),
    .exers0_robid     (exers0_robid),
    .exers0_rd        (exers0_rd),
    .exers0_op1       (exers0_op1),
    .exers0_op2       (exers0_op2),
    .exers1_issue     (exers1_issue),
    .exers1_op        (exers1_op),
    .exers1_robid     (exers1_robid),
    .exers1_rd        (exers1_rd),
    .exers1_op1       (exers1_op1),
    .exers1_op2       (exers1_op2),
    .arb_exers0_stall (arb_exers0_stall),
    .arb_exers1_stall (arb_exers1_stall),
    .arb_scalu_issue  (arb_scalu_issue),
    .arb_scalu_op     (arb_scalu_op),
    .arb_scalu_robid  (arb_scalu_robid),
    .arb_scalu_rd     (arb_scalu_rd),
    .arb_scalu_op1    (arb_scalu_op1),
    .arb_scalu_op2    (arb_scalu_op2),
    .scalu_stall      (scalu_stall),
    .rob_head         (rob_head),
    .rob_flush        (rob_flush)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- field derivation from robid ----------------
  function automatic logic [OP_W-1:0] f_op(input logic [ROBID_W-1:0] r);
    return r[4:0] ^ 5'h15;
  endfunction
  function automatic logic [PREG_W-1:0] f_rd(input logic [ROBID_W-1:0] r);
    return r[6:1] ^ 6'h2A;
  endfunction
  function automatic logic [XLEN-1:0] f_op1(input logic [ROBID_W-1:0] r);
    return {25'h1A5A5A5, r};
  endfunction
  function automatic logic [XLEN-1:0] f_op2(input logic [ROBID_W-1:0] r);
    return {r, 25'h1234567};
  endfunction
  function automatic logic [81:0] f_all(input logic [ROBID_W-1:0] r);
    return {f_op(r), r, f_rd(r), f_op1(r), f_op2(r)};
  endfunction

  function automatic vec_t mk(input logic i0, input logic [ROBID_W-1:0] r0,
                              input logic i1, input logic [ROBID_W-1:0] r1,
                              input logic [ROBID_W-1:0] head, input logic ss, input logic fl,
                              input logic e_iss, input logic [ROBID_W-1:0] e_rid,
                              input logic e_st0, input logic e_st1);
    vec_t v;
    v.iss0 = i0; v.r0 = r0; v.iss1 = i1; v.r1 = r1; v.head = head;
    v.ss = ss; v.fl = fl; v.e_iss = e_iss; v.e_rid = e_rid; v.e_st0 = e_st0; v.e_st1 = e_st1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic i0, input logic [ROBID_W-1:0] r0,
                       input logic i1, input logic [ROBID_W-1:0] r1,
                       input logic [ROBID_W-1:0] head, input logic ss, input logic fl);
    exers0_issue = i0; exers0_robid = r0; exers0_op = f_op(r0); exers0_rd = f_rd(r0);
    exers0_op1 = f_op1(r0); exers0_op2 = f_op2(r0);
    exers1_issue = i1; exers1_robid = r1; exers1_op = f_op(r1); exers1_rd = f_rd(r1);
    exers1_op1 = f_op1(r1); exers1_op2 = f_op2(r1);
    rob_head = head; scalu_stall = ss; rob_flush = fl;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_iss, input logic [ROBID_W-1:0] e_rid,
                          input logic e_st0, input logic e_st1);
    chk({tag, " issue"}, 128'(arb_scalu_issue), 128'(e_iss));
    chk({tag, " stall0"}, 128'(arb_exers0_stall), 128'(e_st0));
    chk({tag, " stall1"}, 128'(arb_exers1_stall), 128'(e_st1));
    if (e_iss)
      chk({tag, " fields"},
          128'({arb_scalu_op, arb_scalu_robid, arb_scalu_rd, arb_scalu_op1, arb_scalu_op2}),
          128'(f_all(e_rid)));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // reset state
    @(negedge clk);
    #1 chk_outs("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // {iss0,r0,iss1,r1,head,scalu_stall,flush | issue,robid,stall0,stall1}
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h05, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 1, 7'h05, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h09, 1, 7'h03, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 1, 7'h03, 1, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 1, 7'h09, 0, 0));
    vq.push_back(mk(1, 7'h01, 1, 7'h7F, 7'h7E, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h7E, 0, 0, 1, 7'h7F, 1, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h7E, 0, 0, 1, 7'h01, 0, 0));
    vq.push_back(mk(1, 7'h20, 1, 7'h20, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 1, 7'h20, 0, 1));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 1, 7'h20, 0, 0));
    vq.push_back(mk(1, 7'h10, 1, 7'h30, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h20, 0, 0, 1, 7'h30, 1, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h20, 0, 0, 1, 7'h10, 0, 0));
    vq.push_back(mk(1, 7'h44, 1, 7'h40, 7'h40, 0, 0, 0, 7'h00, 0, 0));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h40, 1, 0, 0, 7'h00, 1, 1));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h40, 0, 0, 1, 7'h40, 1, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h40, 0, 0, 1, 7'h44, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h11, 0, 7'h00, 7'h00, 1, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h12, 0, 7'h00, 7'h00, 1, 0, 0, 7'h00, 1, 0));
    vq.push_back(mk(1, 7'h12, 0, 7'h00, 7'h00, 0, 0, 1, 7'h11, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 1, 7'h12, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h21, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h22, 0, 7'h00, 7'h00, 0, 0, 1, 7'h21, 0, 0));
    vq.push_back(mk(1, 7'h23, 0, 7'h00, 7'h00, 0, 0, 1, 7'h22, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 1, 7'h23, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h05, 1, 7'h50, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h06, 1, 7'h51, 7'h00, 0, 0, 1, 7'h05, 0, 1));
    vq.push_back(mk(0, 7'h00, 1, 7'h51, 7'h00, 0, 0, 1, 7'h06, 0, 1));
    vq.push_back(mk(0, 7'h00, 1, 7'h51, 7'h00, 0, 0, 1, 7'h50, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 1, 7'h51, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h60, 1, 7'h61, 7'h60, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(0, 7'h00, 1, 7'h62, 7'h60, 0, 1, 1, 7'h60, 0, 1));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h60, 0, 0, 0, 7'h00, 0, 0));
    vq.push_back(mk(1, 7'h70, 0, 7'h00, 7'h00, 0, 1, 0, 7'h00, 0, 0));
    vq.push_back(mk(0, 7'h00, 0, 7'h00, 7'h00, 0, 0, 0, 7'h00, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].iss0, vq[i].r0, vq[i].iss1, vq[i].r1, vq[i].head, vq[i].ss, vq[i].fl);
      #1 chk_outs($sformatf("v%0d", i), vq[i].e_iss, vq[i].e_rid, vq[i].e_st0, vq[i].e_st1);
    end

    // Stall release with wrapped ages; ordering tracked through exp_q.
    @(negedge clk);
    drive(1, 7'h02, 1, 7'h7F, 7'h7E, 1, 0);
    #1 chk_outs("sb fill", 0, 0, 0, 0);
    exp_q.push_back(7'h7F);
    exp_q.push_back(7'h02);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 7'h7E, 1, 0);
      #1 chk_outs($sformatf("sb hold%0d", k), 0, 0, 1, 1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 7'h7E, 0, 0);
      #1;
      if (arb_scalu_issue) begin
        if (exp_q.size() == 0) begin
          chk("sb extra issue", 128'(arb_scalu_robid), 128'h0);
        end else begin
          logic [ROBID_W-1:0] e;
          e = exp_q.pop_front();
          chk("sb order", 128'({arb_scalu_op, arb_scalu_robid, arb_scalu_rd,
                                arb_scalu_op1, arb_scalu_op2}), 128'(f_all(e)));
        end
      end
    end
    chk("sb drained", 128'(exp_q.size()), 128'h0);

    // Asynchronous reset pulse between clock edges.
    @(negedge clk);
    drive(1, 7'h33, 1, 7'h34, 7'h33, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 7'h33, 1, 0);
    #1 chk_outs("pre rst", 0, 0, 1, 1);
    #1 rst = 1'b1;
    #1 chk_outs("in rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 0, 7'h33, 0, 0);
    #1 chk_outs("post rst0", 0, 0, 0, 0);
    @(negedge clk);
    #1 chk_outs("post rst1", 0, 0, 0, 0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
